conv1d_2nd_mac_engine: RTL and testbench



---
 rtl/conv1d_pkg.sv | 42 ++++
 rtl/conv1d_tap3_mac.sv | 39 +++
 rtl/conv1d_2nd_mac_engine.sv | 210 +++++++++++++++++++++
 tb/tb_conv1d_2nd_mac_engine.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared definitions for the CONV1D stages: default sizing, FSM encoding and the
// output saturation/ReLU helper used by every layer's result stage.
package conv1d_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam int NUM_CH    = 8;
  localparam int SEQ_LEN   = 256;
  localparam int ACC_WIDTH = 40;
  localparam int SAT_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } conv_state_t;

  // Clamp to a signed 'bits'-wide range, then optionally zero negatives.
  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] val,
    input int                      bits,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    r  = val;
    if (val > hi) begin
      r = hi;
    end else if (val < lo) begin
      r = lo;
    end
    if (relu && (r < 0)) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv1d_tap3_mac.sv
// Three-tap signed multiply with a registered full-width sum of the products.
module conv1d_tap3_mac #(
  parameter int BIT_WIDTH = conv1d_pkg::BIT_WIDTH,
  parameter int ACC_WIDTH = conv1d_pkg::ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [BIT_WIDTH-1:0] x0,
  input  logic signed [BIT_WIDTH-1:0] x1,
  input  logic signed [BIT_WIDTH-1:0] x2,
  input  logic signed [BIT_WIDTH-1:0] k0,
  input  logic signed [BIT_WIDTH-1:0] k1,
  input  logic signed [BIT_WIDTH-1:0] k2,
  output logic signed [ACC_WIDTH-1:0] tap_sum
);

  localparam int PW = 2 * BIT_WIDTH;

  logic signed [PW-1:0]        p0;
  logic signed [PW-1:0]        p1;
  logic signed [PW-1:0]        p2;
  logic signed [ACC_WIDTH-1:0] sum_c;

  always_comb begin
    p0    = x0 * k0;
    p1    = x1 * k1;
    p2    = x2 * k2;
    sum_c = ACC_WIDTH'(p0) + ACC_WIDTH'(p1) + ACC_WIDTH'(p2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_sum <= '0;
    end else begin
      tap_sum <= sum_c;
    end
  end

endmodule

// File: rtl/conv1d_2nd_mac_engine.sv
// Second CONV1D layer engine: walks filter/width/channel, drives the tap RAM read port,
// accumulates 3x8 products per output and emits one biased, saturated result per position.
module conv1d_2nd_mac_engine #(
  parameter int   BIT_WIDTH   = conv1d_pkg::BIT_WIDTH,
  parameter int   FRAC_BITS   = conv1d_pkg::FRAC_BITS,
  parameter int   NUM_FILTERS = 16,
  parameter int   NUM_CH      = conv1d_pkg::NUM_CH,
  parameter int   SEQ_LEN     = conv1d_pkg::SEQ_LEN,
  parameter int   ACC_WIDTH   = conv1d_pkg::ACC_WIDTH,
  parameter int   RELU_EN     = 1,
  localparam int  FW          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        Read_Enable,
  output logic [2:0]                  Read_Depth,
  output logic [7:0]                  Read_Width,
  input  logic signed [BIT_WIDTH-1:0] data_in_0,
  input  logic signed [BIT_WIDTH-1:0] data_in_1,
  input  logic signed [BIT_WIDTH-1:0] data_in_2,
  output logic [FW+2:0]               Weight_Addr,
  input  logic signed [BIT_WIDTH-1:0] Weight_0,
  input  logic signed [BIT_WIDTH-1:0] Weight_1,
  input  logic signed [BIT_WIDTH-1:0] Weight_2,
  output logic [FW-1:0]               Bias_Addr,
  input  logic signed [BIT_WIDTH-1:0] Bias_in,
  output logic                        out_valid,
  output logic [FW-1:0]               out_filter,
  output logic [7:0]                  out_width,
  output logic signed [BIT_WIDTH-1:0] out_data
);

  import conv1d_pkg::conv_state_t;
  import conv1d_pkg::ST_IDLE;
  import conv1d_pkg::ST_RUN;
  import conv1d_pkg::ST_DRAIN;
  import conv1d_pkg::ST_DONE;
  import conv1d_pkg::SAT_W;
  import conv1d_pkg::sat_relu;

  conv_state_t state, state_nxt;

  logic [FW-1:0] f_cnt;
  logic [7:0]    w_cnt;
  logic [2:0]    c_cnt;
  logic          last_issue;
  logic [FW-1:0] rd_f;

  logic signed [ACC_WIDTH-1:0] tap_sum;
  logic                        s1_valid;
  logic [2:0]                  s1_c;
  logic [FW-1:0]               s1_f;
  logic [7:0]                  s1_w;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        s2_valid;
  logic                        s2_last;
  logic [FW-1:0]               s2_f;
  logic [7:0]                  s2_w;

  logic signed [SAT_W-1:0] biased;
  logic signed [SAT_W-1:0] res_sat;

  assign last_issue = (f_cnt == FW'(NUM_FILTERS - 1)) &&
                      (w_cnt == 8'(SEQ_LEN - 1)) &&
                      (c_cnt == 3'(NUM_CH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Empty means no issued read and no tagged beat left ahead of S3.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!Read_Enable && !s1_valid && !s2_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || (state != ST_RUN)) begin
      c_cnt <= '0;
      w_cnt <= '0;
      f_cnt <= '0;
    end else begin
      c_cnt <= c_cnt + 3'd1;
      if (c_cnt == 3'(NUM_CH - 1)) begin
        c_cnt <= '0;
        w_cnt <= w_cnt + 8'd1;
        if (w_cnt == 8'(SEQ_LEN - 1)) begin
          w_cnt <= '0;
          f_cnt <= (f_cnt == FW'(NUM_FILTERS - 1)) ? '0 : f_cnt + FW'(1);
        end
      end
    end
  end

  // Read port is registered, so the first read leaves one edge after RUN is entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Read_Enable <= 1'b0;
      Read_Depth  <= '0;
      Read_Width  <= '0;
      rd_f        <= '0;
    end else begin
      Read_Enable <= (state == ST_RUN);
      if (state == ST_RUN) begin
        Read_Depth <= c_cnt;
        Read_Width <= w_cnt;
        rd_f       <= f_cnt;
      end
    end
  end

  assign Weight_Addr = {rd_f, Read_Depth};

  conv1d_tap3_mac #(
    .BIT_WIDTH (BIT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (CLK),
    .rst     (RST),
    .x0      (data_in_0),
    .x1      (data_in_1),
    .x2      (data_in_2),
    .k0      (Weight_0),
    .k1      (Weight_1),
    .k2      (Weight_2),
    .tap_sum (tap_sum)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_c     <= '0;
      s1_f     <= '0;
      s1_w     <= '0;
    end else begin
      s1_valid <= Read_Enable;
      s1_c     <= Read_Depth;
      s1_f     <= rd_f;
      s1_w     <= Read_Width;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc      <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_f     <= '0;
      s2_w     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && (s1_c == 3'(NUM_CH - 1));
      s2_f     <= s1_f;
      s2_w     <= s1_w;
      if (s1_valid) begin
        acc <= (s1_c == '0) ? tap_sum : acc + tap_sum;
      end
    end
  end

  // Bias is looked up with the filter tag of the accumulation being finished.
  assign Bias_Addr = s2_f;

  always_comb begin
    biased  = SAT_W'(acc) + (SAT_W'(Bias_in) <<< FRAC_BITS);
    res_sat = sat_relu(biased >>> FRAC_BITS, BIT_WIDTH, RELU_EN != 0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid  <= 1'b0;
      out_filter <= '0;
      out_width  <= '0;
      out_data   <= '0;
    end else begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid && s2_last) begin
        out_filter <= s2_f;
        out_width  <= s2_w;
        out_data   <= BIT_WIDTH'(res_sat);
      end
    end
  end

endmodule

// File: tb/tb_conv1d_2nd_mac_engine.sv
// Directed bench: two engines (2 filters without ReLU, 1 filter with ReLU) fed by
// behavioural tap/weight/bias memories, checked against hand-computed results.
module tb_conv1d_2nd_mac_engine;

  localparam int PASS_LIMIT = 4400;

  logic CLK;
  logic RST;
  logic start;

  logic              a_busy, a_done, a_re, a_ov;
  logic [2:0]        a_rd;
  logic [7:0]        a_rw, a_ow;
  logic signed [15:0] a_d0, a_d1, a_d2, a_k0, a_k1, a_k2, a_bias, a_od;
  logic [3:0]        a_wa;
  logic [0:0]        a_ba, a_of;

  logic              b_busy, b_done, b_re, b_ov;
  logic [2:0]        b_rd;
  logic [7:0]        b_rw, b_ow;
  logic signed [15:0] b_d0, b_d1, b_d2, b_k0, b_k1, b_k2, b_bias, b_od;
  logic [3:0]        b_wa;
  logic [0:0]        b_ba, b_of;

  logic signed [15:0] xmem [8][256];
  logic signed [15:0] kmem [2][8][3];
  logic signed [15:0] bmem [2];

  logic signed [15:0] a_res [512];
  logic signed [15:0] b_res [512];
  logic signed [15:0] exp_a [512];
  logic signed [15:0] exp_b [512];

  int n_checks, n_fail;
  int a_cnt, b_cnt, a_order_err, b_order_err, a_done_n, b_done_n;
  int a_first_t, b_first_t, a_last_t, a_done_t;
  logic a_re_t0, a_re_t1, a_busy_t0, a_busy_at_done;

  conv1d_2nd_mac_engine #(.NUM_FILTERS(2), .RELU_EN(0)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(a_busy), .done(a_done),
    .Read_Enable(a_re), .Read_Depth(a_rd), .Read_Width(a_rw),
    .data_in_0(a_d0), .data_in_1(a_d1), .data_in_2(a_d2),
    .Weight_Addr(a_wa), .Weight_0(a_k0), .Weight_1(a_k1), .Weight_2(a_k2),
    .Bias_Addr(a_ba), .Bias_in(a_bias),
    .out_valid(a_ov), .out_filter(a_of), .out_width(a_ow), .out_data(a_od)
  );

  conv1d_2nd_mac_engine #(.NUM_FILTERS(1), .RELU_EN(1)) u_relu (
    .CLK(CLK), .RST(RST), .start(start), .busy(b_busy), .done(b_done),
    .Read_Enable(b_re), .Read_Depth(b_rd), .Read_Width(b_rw),
    .data_in_0(b_d0), .data_in_1(b_d1), .data_in_2(b_d2),
    .Weight_Addr(b_wa), .Weight_0(b_k0), .Weight_1(b_k1), .Weight_2(b_k2),
    .Bias_Addr(b_ba), .Bias_in(b_bias),
    .out_valid(b_ov), .out_filter(b_of), .out_width(b_ow), .out_data(b_od)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM models: outputs change on negedge from the addresses issued at the prior posedge.
  always @(negedge CLK) begin
    a_d0 <= (a_rw == 8'd0)   ? 16'sd0 : xmem[a_rd][a_rw - 8'd1];
    a_d1 <= xmem[a_rd][a_rw];
    a_d2 <= (a_rw == 8'd255) ? 16'sd0 : xmem[a_rd][a_rw + 8'd1];
    a_k0 <= kmem[a_wa[3]][a_wa[2:0]][0];
    a_k1 <= kmem[a_wa[3]][a_wa[2:0]][1];
    a_k2 <= kmem[a_wa[3]][a_wa[2:0]][2];
    b_d0 <= (b_rw == 8'd0)   ? 16'sd0 : xmem[b_rd][b_rw - 8'd1];
    b_d1 <= xmem[b_rd][b_rw];
    b_d2 <= (b_rw == 8'd255) ? 16'sd0 : xmem[b_rd][b_rw + 8'd1];
    b_k0 <= kmem[b_wa[3]][b_wa[2:0]][0];
    b_k1 <= kmem[b_wa[3]][b_wa[2:0]][1];
    b_k2 <= kmem[b_wa[3]][b_wa[2:0]][2];
  end

  assign a_bias = bmem[a_ba];
  assign b_bias = bmem[b_ba];

  task automatic set_data(input logic signed [15:0] v);
    for (int c = 0; c < 8; c++)
      for (int w = 0; w < 256; w++) xmem[c][w] = v;
  endtask

  task automatic set_weights(input logic signed [15:0] k0, input logic signed [15:0] k1,
                             input logic signed [15:0] k2);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 8; c++) begin
        kmem[f][c][0] = k0;
        kmem[f][c][1] = k1;
        kmem[f][c][2] = k2;
      end
  endtask

  task automatic set_bias(input logic signed [15:0] b0, input logic signed [15:0] b1);
    bmem[0] = b0;
    bmem[1] = b1;
  endtask

  function automatic int count_bad(input logic signed [15:0] got [512],
                                   input logic signed [15:0] want [512],
                                   input int n, output int first);
    int bad;
    bad   = 0;
    first = 0;
    for (int i = 0; i < n; i++) begin
      if (got[i] !== want[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    return bad;
  endfunction

  // One start pulse, then capture every beat of both engines until done (bounded).
  task automatic run_pass(input int extra_start_at);
    int t;
    int idx;
    for (int i = 0; i < 512; i++) begin
      a_res[i] = 16'sd12345;
      b_res[i] = 16'sd12345;
    end
    a_cnt = 0; b_cnt = 0; a_order_err = 0; b_order_err = 0;
    a_done_n = 0; b_done_n = 0;
    a_first_t = -1; b_first_t = -1; a_last_t = -1; a_done_t = -1;
    a_busy_at_done = 1'b1; a_re_t1 = 1'b0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    t = 0;
    a_re_t0   = a_re;
    a_busy_t0 = a_busy;
    while (!(a_done_n > 0 && b_done_n > 0 && t >= a_done_t + 5) && t < PASS_LIMIT) begin
      @(negedge CLK);
      t++;
      start = (t == extra_start_at);
      if (t == 1) a_re_t1 = a_re;
      if (a_ov) begin
        idx = int'({a_of, a_ow});
        if (idx != a_cnt) a_order_err++;
        a_res[idx] = a_od;
        if (a_first_t < 0) a_first_t = t;
        a_last_t = t;
        a_cnt++;
      end
      if (b_ov) begin
        idx = int'({b_of, b_ow});
        if (idx != b_cnt) b_order_err++;
        b_res[idx] = b_od;
        if (b_first_t < 0) b_first_t = t;
        b_cnt++;
      end
      if (a_done) begin
        if (a_done_n == 0) begin
          a_done_t       = t;
          a_busy_at_done = a_busy;
        end
        a_done_n++;
      end
      if (b_done) b_done_n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({a_busy, a_done, a_re, a_ov} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_a_ctrl: busy/done/re/valid=%b want 0000", {a_busy, a_done, a_re, a_ov});
    end
    n_checks++;
    if ({a_rd, a_rw, a_wa, a_ba, a_of, a_ow, a_od} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_bus: rd=%0d rw=%0d wa=%0d ba=%0d of=%0d ow=%0d od=%0d want all 0",
               a_rd, a_rw, a_wa, a_ba, a_of, a_ow, a_od);
    end
    n_checks++;
    if ({b_busy, b_done, b_re, b_ov, b_od} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: busy/done/re/valid=%b od=%0d want 0", {b_busy, b_done, b_re, b_ov}, b_od);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({a_busy, a_re, a_ov, a_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/re/valid/done=%b want 0000", {a_busy, a_re, a_ov, a_done});
    end
  endtask

  task automatic test_uniform();
    int fi;
    int bad;
    set_data(16'sd256); set_weights(16'sd256, 16'sd256, 16'sd256); set_bias(16'sd0, 16'sd0);
    for (int i = 0; i < 512; i++) begin
      exp_a[i] = ((i % 256) == 0 || (i % 256) == 255) ? 16'sd4096 : 16'sd6144;
      exp_b[i] = exp_a[i];
    end
    run_pass(40);
    n_checks++;
    if (a_cnt !== 512) begin n_fail++; $display("FAIL uniform_a_count: got %0d want 512", a_cnt); end
    n_checks++;
    if (a_order_err !== 0) begin n_fail++; $display("FAIL uniform_a_order: %0d beats out of f-major order, want 0", a_order_err); end
    bad = count_bad(a_res, exp_a, 512, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL uniform_a_data: %0d wrong, idx %0d got %0d want %0d", bad, fi, a_res[fi], exp_a[fi]);
    end
    n_checks++;
    if (b_cnt !== 256) begin n_fail++; $display("FAIL uniform_b_count: got %0d want 256", b_cnt); end
    bad = count_bad(b_res, exp_b, 256, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL uniform_b_data: %0d wrong, idx %0d got %0d want %0d", bad, fi, b_res[fi], exp_b[fi]);
    end
    n_checks++;
    if (a_first_t !== 11) begin n_fail++; $display("FAIL latency_a: first out_valid at %0d want 11", a_first_t); end
    n_checks++;
    if (b_first_t !== 11) begin n_fail++; $display("FAIL latency_b: first out_valid at %0d want 11", b_first_t); end
    n_checks++;
    if ({a_busy_t0, a_re_t0, a_re_t1} !== 3'b101) begin
      n_fail++;
      $display("FAIL start_handshake: busy0/re0/re1=%b want 101", {a_busy_t0, a_re_t0, a_re_t1});
    end
    n_checks++;
    if (a_done_n !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", a_done_n); end
    n_checks++;
    if (a_done_t !== a_last_t + 1) begin
      n_fail++;
      $display("FAIL done_timing: done at %0d want %0d", a_done_t, a_last_t + 1);
    end
    n_checks++;
    if ({a_busy_at_done, a_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_fall: busy at done/after=%b want 00", {a_busy_at_done, a_busy});
    end
  endtask

  task automatic test_impulse();
    int fi;
    int bad;
    set_data(16'sd0); xmem[3][10] = 16'sd256;
    set_weights(16'sd256, 16'sd512, 16'sd768); set_bias(16'sd0, 16'sd0);
    for (int i = 0; i < 512; i++) begin
      case (i % 256)
        9:       exp_a[i] = 16'sd768;
        10:      exp_a[i] = 16'sd512;
        11:      exp_a[i] = 16'sd256;
        default: exp_a[i] = 16'sd0;
      endcase
      exp_b[i] = exp_a[i];
    end
    run_pass(-1);
    bad = count_bad(a_res, exp_a, 512, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL impulse_a: %0d wrong, idx %0d got %0d want %0d", bad, fi, a_res[fi], exp_a[fi]);
    end
    bad = count_bad(b_res, exp_b, 256, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL impulse_b: %0d wrong, idx %0d got %0d want %0d", bad, fi, b_res[fi], exp_b[fi]);
    end
  endtask

  task automatic test_saturation();
    int fi;
    int bad;
    set_data(16'sd32512); set_weights(16'sd32512, 16'sd32512, 16'sd32512); set_bias(16'sd0, 16'sd0);
    for (int i = 0; i < 512; i++) begin
      exp_a[i] = 16'sd32767;
      exp_b[i] = 16'sd32767;
    end
    run_pass(-1);
    bad = count_bad(a_res, exp_a, 512, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sat_pos_a: %0d wrong, idx %0d got %0d want %0d", bad, fi, a_res[fi], exp_a[fi]);
    end
    bad = count_bad(b_res, exp_b, 256, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sat_pos_b: %0d wrong, idx %0d got %0d want %0d", bad, fi, b_res[fi], exp_b[fi]);
    end
    set_weights(-16'sd32512, -16'sd32512, -16'sd32512);
    for (int i = 0; i < 512; i++) begin
      exp_a[i] = -16'sd32768;
      exp_b[i] = 16'sd0;
    end
    run_pass(-1);
    bad = count_bad(a_res, exp_a, 512, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sat_neg_a: %0d wrong, idx %0d got %0d want %0d", bad, fi, a_res[fi], exp_a[fi]);
    end
    bad = count_bad(b_res, exp_b, 256, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL relu_neg_b: %0d wrong, idx %0d got %0d want %0d", bad, fi, b_res[fi], exp_b[fi]);
    end
  endtask

  task automatic test_bias();
    int fi;
    int bad;
    set_data(16'sd0); set_weights(16'sd256, 16'sd256, 16'sd256); set_bias(-16'sd256, -16'sd512);
    for (int i = 0; i < 512; i++) begin
      exp_a[i] = (i < 256) ? -16'sd256 : -16'sd512;
      exp_b[i] = 16'sd0;
    end
    run_pass(-1);
    bad = count_bad(a_res, exp_a, 512, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bias_a: %0d wrong, idx %0d got %0d want %0d", bad, fi, a_res[fi], exp_a[fi]);
    end
    n_checks++;
    if ({a_order_err, a_cnt} !== {32'd0, 32'd512}) begin
      n_fail++;
      $display("FAIL bias_a_seq: order errors %0d count %0d want 0 and 512", a_order_err, a_cnt);
    end
    bad = count_bad(b_res, exp_b, 256, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bias_relu_b: %0d wrong, idx %0d got %0d want %0d", bad, fi, b_res[fi], exp_b[fi]);
    end
  endtask

  task automatic test_reset_midrun();
    int fi;
    int bad;
    int stray;
    set_data(16'sd256); set_weights(16'sd256, 16'sd256, 16'sd256); set_bias(16'sd0, 16'sd0);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (99) @(negedge CLK);
    n_checks++;
    if ({a_busy, a_re} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrun_active: busy/re=%b want 11", {a_busy, a_re});
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if ({a_busy, a_re, a_ov, a_done, b_busy, b_re} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy/re/valid/done/b_busy/b_re=%b want 000000",
               {a_busy, a_re, a_ov, a_done, b_busy, b_re});
    end
    stray = 0;
    repeat (40) begin
      @(negedge CLK);
      if (a_ov || a_done || a_busy || b_ov || b_done || b_busy) stray++;
    end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles after reset want 0", stray); end
    for (int i = 0; i < 512; i++) begin
      exp_a[i] = ((i % 256) == 0 || (i % 256) == 255) ? 16'sd4096 : 16'sd6144;
      exp_b[i] = exp_a[i];
    end
    run_pass(-1);
    n_checks++;
    if ({a_cnt, a_done_n} !== {32'd512, 32'd1}) begin
      n_fail++;
      $display("FAIL rerun_count: count %0d done %0d want 512 and 1", a_cnt, a_done_n);
    end
    bad = count_bad(a_res, exp_a, 512, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rerun_a: %0d wrong, idx %0d got %0d want %0d", bad, fi, a_res[fi], exp_a[fi]);
    end
    bad = count_bad(b_res, exp_b, 256, fi);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rerun_b: %0d wrong, idx %0d got %0d want %0d", bad, fi, b_res[fi], exp_b[fi]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    RST      = 1'b1;
    set_data(16'sd0);
    set_weights(16'sd0, 16'sd0, 16'sd0);
    set_bias(16'sd0, 16'sd0);
    test_reset();
    test_uniform();
    test_impulse();
    test_saturation();
    test_bias();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
